// File: rtl/spad_regfile_pkg.sv
// Shared types and constants for the scratchpad register file.
package spad_regfile_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

endpackage

// File: rtl/spad_regfile_bank.sv
// One byte-writable register bank with an asynchronous (combinational) read port.
module spad_bank
    import spad_regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                     clk_h,
    input  logic                     we_h,
    input  logic [ADDR_W-1:0]        addr_h,
    input  logic [DATA_W/BYTE_W-1:0] be_h,
    input  logic [DATA_W-1:0]        wdata_h,
    output logic [DATA_W-1:0]        rdata_h
);

    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_h) begin
        if (we_h) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be_h[b]) begin
                    mem_q[addr_h][b*BYTE_W +: BYTE_W] <= wdata_h[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rdata_h = mem_q[addr_h];

endmodule

// File: rtl/spad_regfile.sv
// Multi-bank scratchpad register file: clear sequencer, write-first read bypass,
// and an active-low registered read bus.
module spad_regfile
    import spad_regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NBANKS = 2
) (
    input  logic                                  clk_h,
    input  logic                                  rst_h,
    input  logic [ADDR_W-1:0]                     mspa_h,
    input  logic [(NBANKS>1 ? $clog2(NBANKS):1)-1:0] bank_h,
    input  logic [DATA_W-1:0]                     wbus_h,
    input  logic [DATA_W/8-1:0]                   spw_l,
    input  logic                                  mcs_l,
    input  logic                                  clr_h,
    output logic [DATA_W-1:0]                     mbus_l,
    output logic                                  mbus_oe_h,
    output logic                                  busy_h
);

    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int TOTAL  = NBANKS * DEPTH;
    localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int PTR_W  = $clog2(TOTAL);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TOTAL - 1);

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] mbus_q, mbus_d;
    logic              oe_q, oe_d;

    logic              idle;
    logic              bank_ok;
    logic [NBANKS-1:0] sel;
    logic [NBANKS-1:0] bank_we;
    logic [ADDR_W-1:0] bank_addr;
    logic [NBYTES-1:0] bank_be;
    logic [DATA_W-1:0] bank_wdata;
    logic [DATA_W-1:0] rdata [NBANKS];
    logic [DATA_W-1:0] rd_old;
    logic [DATA_W-1:0] rd_new;

    // Bank port steering: the clear sequencer owns every bank port while busy.
    always_comb begin
        idle = (state_q == ST_IDLE);
        for (int i = 0; i < NBANKS; i++) begin
            sel[i] = (bank_h == BANK_W'(i));
        end
        bank_ok = |sel;
        if (idle) begin
            bank_addr  = mspa_h;
            bank_be    = ~spw_l;
            bank_wdata = wbus_h;
            bank_we    = sel;
        end else begin
            bank_addr  = ptr_q[ADDR_W-1:0];
            bank_be    = '1;
            bank_wdata = '0;
            for (int i = 0; i < NBANKS; i++) begin
                bank_we[i] = ((ptr_q >> ADDR_W) == PTR_W'(i));
            end
        end
    end

    for (genvar i = 0; i < NBANKS; i++) begin : g_bank
        spad_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk_h   (clk_h),
            .we_h    (bank_we[i]),
            .addr_h  (bank_addr),
            .be_h    (bank_be),
            .wdata_h (bank_wdata),
            .rdata_h (rdata[i])
        );
    end

    // Read mux plus per-byte write-first bypass; read and write share one address.
    always_comb begin
        rd_old = '0;
        for (int i = 0; i < NBANKS; i++) begin
            if (sel[i]) begin
                rd_old = rdata[i];
            end
        end
        for (int b = 0; b < NBYTES; b++) begin
            rd_new[b*BYTE_W +: BYTE_W] = spw_l[b] ? rd_old[b*BYTE_W +: BYTE_W]
                                                  : wbus_h[b*BYTE_W +: BYTE_W];
        end
        mbus_d = '1;
        oe_d   = 1'b0;
        if (idle && bank_ok && !mcs_l) begin
            mbus_d = ~rd_new;
            oe_d   = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + PTR_W'(1);
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            ST_IDLE: begin
                if (clr_h) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            mbus_q  <= '1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mbus_q  <= mbus_d;
            oe_q    <= oe_d;
        end
    end

    assign mbus_l    = mbus_q;
    assign mbus_oe_h = oe_q;
    assign busy_h    = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_spad_regfile.sv
// Bench for spad_regfile: default instance plus a DATA_W=16/ADDR_W=3/NBANKS=3 instance.
module tb_spad_regfile;

    logic clk_h = 1'b0;
    always #5 clk_h = ~clk_h;

    logic        rst_h, clr_h, mcs_l;
    logic [3:0]  mspa_h;
    logic [0:0]  bank_h;
    logic [31:0] wbus_h;
    logic [3:0]  spw_l;
    logic [31:0] mbus_l;
    logic        mbus_oe_h, busy_h;

    logic        p_rst, p_clr, p_mcs;
    logic [2:0]  p_mspa;
    logic [1:0]  p_bank;
    logic [15:0] p_wbus;
    logic [1:0]  p_spw;
    logic [15:0] p_mbus;
    logic        p_oe, p_busy;

    spad_regfile dut (
        .clk_h(clk_h), .rst_h(rst_h), .mspa_h(mspa_h), .bank_h(bank_h),
        .wbus_h(wbus_h), .spw_l(spw_l), .mcs_l(mcs_l), .clr_h(clr_h),
        .mbus_l(mbus_l), .mbus_oe_h(mbus_oe_h), .busy_h(busy_h)
    );

    spad_regfile #(.DATA_W(16), .ADDR_W(3), .NBANKS(3)) dut_p (
        .clk_h(clk_h), .rst_h(p_rst), .mspa_h(p_mspa), .bank_h(p_bank),
        .wbus_h(p_wbus), .spw_l(p_spw), .mcs_l(p_mcs), .clr_h(p_clr),
        .mbus_l(p_mbus), .mbus_oe_h(p_oe), .busy_h(p_busy)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] model [2][16];

    task automatic tick();
        @(posedge clk_h);
        #1;
    endtask

    task automatic idle_inputs();
        clr_h  = 1'b0;
        mcs_l  = 1'b1;
        spw_l  = 4'hF;
        wbus_h = '0;
        mspa_h = '0;
        bank_h = '0;
    endtask

    task automatic clear_model();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 16; a++)
                model[b][a] = '0;
    endtask

    // Applies one IDLE access to the model and returns the expected read bus.
    task automatic model_access(input int b, input int a, input logic [31:0] d,
                                input logic [3:0] m, input logic cs,
                                output logic [31:0] exp_bus, output logic exp_oe);
        logic [31:0] nv;
        nv = model[b][a];
        for (int k = 0; k < 4; k++)
            if (!m[k]) nv[8*k +: 8] = d[8*k +: 8];
        model[b][a] = nv;
        exp_bus = cs ? 32'hFFFF_FFFF : ~nv;
        exp_oe  = !cs;
    endtask

    task automatic read_all(input string tag);
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 16; a++) begin
                idle_inputs();
                bank_h = 1'(b);
                mspa_h = 4'(a);
                mcs_l  = 1'b0;
                tick();
                n_chk++;
                if (mbus_l !== ~model[b][a] || mbus_oe_h !== 1'b1)
                    $display("FAIL %s b%0d a%0d mbus=%h oe=%b expected mbus=%h oe=1",
                             tag, b, a, mbus_l, mbus_oe_h, ~model[b][a]);
                else n_pass++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        rst_h = 1'b1;
        tick();
        n_chk++;
        if (busy_h !== 1'b1 || mbus_l !== 32'hFFFF_FFFF || mbus_oe_h !== 1'b0)
            $display("FAIL reset_state busy=%b mbus=%h oe=%b expected busy=1 mbus=ffffffff oe=0",
                     busy_h, mbus_l, mbus_oe_h);
        else n_pass++;
        rst_h = 1'b0;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            n++;
            if (!busy_h) break;
        end
        n_chk++;
        if (n !== 32) $display("FAIL reset_busy_len got %0d cycles expected 32", n);
        else n_pass++;
        clear_model();
        read_all("reset_read");
    endtask

    task automatic test_write_read();
        logic [31:0] eb;
        logic        eo;
        idle_inputs();
        bank_h = 1'b1; mspa_h = 4'd5; wbus_h = 32'h1234_5678; spw_l = 4'b0000;
        model_access(1, 5, 32'h1234_5678, 4'b0000, 1'b1, eb, eo);
        tick();
        idle_inputs();
        bank_h = 1'b1; mspa_h = 4'd5; mcs_l = 1'b0;
        tick();
        n_chk++;
        if (mbus_l !== 32'hEDCB_A987 || mbus_oe_h !== 1'b1)
            $display("FAIL wr_rd_b1 mbus=%h oe=%b expected mbus=edcba987 oe=1", mbus_l, mbus_oe_h);
        else n_pass++;
        bank_h = 1'b0;
        tick();
        n_chk++;
        if (mbus_l !== 32'hFFFF_FFFF || mbus_oe_h !== 1'b1)
            $display("FAIL wr_rd_b0 mbus=%h oe=%b expected mbus=ffffffff oe=1", mbus_l, mbus_oe_h);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_random();
        int b, a;
        logic [31:0] d, eb;
        logic [3:0]  m;
        logic        cs, eo;
        for (int it = 0; it < 200; it++) begin
            b  = $urandom_range(0, 1);
            a  = $urandom_range(0, 15);
            d  = $urandom;
            m  = 4'($urandom_range(0, 15));
            cs = 1'($urandom_range(0, 1));
            model_access(b, a, d, m, cs, eb, eo);
            bank_h = 1'(b); mspa_h = 4'(a); wbus_h = d; spw_l = m; mcs_l = cs;
            clr_h = 1'b0;
            tick();
            n_chk++;
            if (mbus_l !== eb || mbus_oe_h !== eo)
                $display("FAIL random it%0d mbus=%h oe=%b expected mbus=%h oe=%b",
                         it, mbus_l, mbus_oe_h, eb, eo);
            else n_pass++;
        end
        idle_inputs();
        read_all("random_read");
    endtask

    task automatic test_bypass();
        logic [31:0] eb;
        logic        eo;
        idle_inputs();
        bank_h = 1'b0; mspa_h = 4'd3; wbus_h = 32'h1122_3344; spw_l = 4'b0000;
        model_access(0, 3, 32'h1122_3344, 4'b0000, 1'b1, eb, eo);
        tick();
        wbus_h = 32'hAABB_CCDD; spw_l = 4'b1010; mcs_l = 1'b0;
        model_access(0, 3, 32'hAABB_CCDD, 4'b1010, 1'b0, eb, eo);
        tick();
        n_chk++;
        if (mbus_l !== ~32'h11BB_33DD || mbus_oe_h !== 1'b1)
            $display("FAIL bypass_same_cycle mbus=%h expected %h", mbus_l, ~32'h11BB_33DD);
        else n_pass++;
        spw_l = 4'hF;
        tick();
        n_chk++;
        if (mbus_l !== ~32'h11BB_33DD || model[0][3] !== 32'h11BB_33DD)
            $display("FAIL bypass_stored mbus=%h expected %h", mbus_l, ~32'h11BB_33DD);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_clear();
        int  n;
        bit  oe_seen;
        idle_inputs();
        bank_h = 1'b0; mspa_h = 4'd7; wbus_h = 32'hDEAD_BEEF; spw_l = 4'b0000; clr_h = 1'b1;
        tick();
        n_chk++;
        if (busy_h !== 1'b1 || mbus_oe_h !== 1'b0)
            $display("FAIL clear_enter busy=%b oe=%b expected busy=1 oe=0", busy_h, mbus_oe_h);
        else n_pass++;
        n = 0;
        oe_seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            bank_h = 1'($urandom_range(0, 1));
            mspa_h = 4'($urandom_range(0, 15));
            wbus_h = $urandom;
            spw_l  = 4'b0000;
            mcs_l  = 1'b0;
            clr_h  = 1'($urandom_range(0, 1));
            tick();
            n++;
            if (mbus_oe_h !== 1'b0 || mbus_l !== 32'hFFFF_FFFF) oe_seen = 1'b1;
            if (!busy_h) break;
        end
        n_chk++;
        if (n !== 32) $display("FAIL clear_busy_len got %0d cycles expected 32", n);
        else n_pass++;
        n_chk++;
        if (oe_seen) $display("FAIL clear_bus_released got oe=1 during clear expected oe=0");
        else n_pass++;
        clear_model();
        read_all("clear_read");
    endtask

    task automatic test_reset_mid_clear();
        int n;
        idle_inputs();
        clr_h = 1'b1;
        tick();
        clr_h = 1'b0;
        repeat (10) tick();
        n_chk++;
        if (busy_h !== 1'b1) $display("FAIL midclr_busy got %b expected 1", busy_h);
        else n_pass++;
        rst_h = 1'b1;
        tick();
        rst_h = 1'b0;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            n++;
            if (!busy_h) break;
        end
        n_chk++;
        if (n !== 32) $display("FAIL midclr_restart_len got %0d cycles expected 32", n);
        else n_pass++;
    endtask

    task automatic test_params();
        int n;
        logic [15:0] exp_p [3];
        p_rst = 1'b1; p_clr = 1'b0; p_mcs = 1'b1; p_spw = 2'b11; p_wbus = '0;
        p_mspa = '0; p_bank = '0;
        tick();
        p_rst = 1'b0;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            n++;
            if (!p_busy) break;
        end
        n_chk++;
        if (n !== 24) $display("FAIL param_busy_len got %0d cycles expected 24", n);
        else n_pass++;
        p_bank = 2'd1; p_mspa = 3'd2; p_wbus = 16'hBEEF; p_spw = 2'b00;
        tick();
        p_bank = 2'd3; p_wbus = 16'h1234;
        tick();
        p_spw = 2'b11; p_mcs = 1'b0;
        tick();
        n_chk++;
        if (p_mbus !== 16'hFFFF || p_oe !== 1'b0)
            $display("FAIL param_bad_bank_read mbus=%h oe=%b expected mbus=ffff oe=0", p_mbus, p_oe);
        else n_pass++;
        exp_p[0] = 16'hFFFF;
        exp_p[1] = ~16'hBEEF;
        exp_p[2] = 16'hFFFF;
        for (int b = 0; b < 3; b++) begin
            p_bank = 2'(b);
            tick();
            n_chk++;
            if (p_mbus !== exp_p[b] || p_oe !== 1'b1)
                $display("FAIL param_read_b%0d mbus=%h oe=%b expected mbus=%h oe=1",
                         b, p_mbus, p_oe, exp_p[b]);
            else n_pass++;
        end
        p_mcs = 1'b1;
    endtask

    initial begin
        rst_h = 1'b0;
        idle_inputs();
        p_rst = 1'b1; p_clr = 1'b0; p_mcs = 1'b1; p_spw = 2'b11; p_wbus = '0;
        p_mspa = '0; p_bank = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_random();
        test_clear();
        test_reset_mid_clear();
        test_params();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/spad_regfile.md
SPAD_REGFILE -- requirements
Module: spad_regfile

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 4, entry address width; depth per bank = 2**ADDR_W.
REQ-003 Parameter NBANKS, default 2, number of register banks; SHALL be >= 1.
REQ-004 clk_h  in  1  single clock; all state updates on rising edge.
REQ-005 rst_h  in  1  reset, synchronous, active-high.
REQ-006 mspa_h  in  ADDR_W  scratchpad entry address, shared by read and write.
REQ-007 bank_h  in  max(1,clog2(NBANKS))  bank select, shared by read and write; values >= NBANKS select nothing.
REQ-008 wbus_h  in  DATA_W  W data bus write data.
REQ-009 spw_l  in  DATA_W/8  per-byte write enables, active low.
REQ-010 mcs_l  in  1  read chip select, active low.
REQ-011 clr_h  in  1  request to zero all banks.
REQ-012 mbus_l  out  DATA_W  M data bus read data, active low, registered.
REQ-013 mbus_oe_h  out  1  mbus_l holds valid read data this cycle.
REQ-014 busy_h  out  1  clear sequence in progress.

Function
REQ-015 States SHALL be CLEAR and IDLE; the clear pointer SHALL span NBANKS*2**ADDR_W entries.
REQ-016 In CLEAR, one entry per cycle SHALL be written to zero, in bank-major, address-ascending order; busy_h SHALL be 1.
REQ-017 CLEAR SHALL exit to IDLE on the cycle after the last entry is zeroed; busy_h SHALL fall in the same cycle.
REQ-018 In IDLE, clr_h=1 SHALL enter CLEAR with the pointer at 0 on the next edge; clr_h during CLEAR SHALL be ignored.
REQ-019 In IDLE, each byte b with spw_l[b]=0 SHALL write wbus_h[8b+7:8b] to mem[bank_h][mspa_h] at the edge; other bytes SHALL be unchanged.
REQ-020 In IDLE, mcs_l=0 SHALL register ~mem[bank_h][mspa_h] into mbus_l and set mbus_oe_h=1 on the next edge (1-cycle latency).
REQ-021 A read and write to the same bank/address in the same cycle SHALL return the new data for written bytes and the old data for unwritten bytes (write-first, per byte).
REQ-022 If mcs_l=1, in CLEAR, or if bank_h >= NBANKS, the next-cycle outputs SHALL be mbus_l = all ones (released bus) and mbus_oe_h=0.
REQ-023 Writes to bank_h >= NBANKS, and all writes or reads during CLEAR, SHALL be dropped with no state change.
REQ-024 clr_h arriving in the same cycle as a write in IDLE SHALL still perform the write; CLEAR then overwrites it.

Reset
REQ-025 rst_h=1 at an edge SHALL force state CLEAR, pointer 0, mbus_l all ones, mbus_oe_h 0, busy_h 1.
REQ-026 Reset asserted mid-CLEAR SHALL restart clearing from pointer 0.
REQ-027 After rst_h deasserts, busy_h SHALL stay 1 for exactly NBANKS*2**ADDR_W cycles (32 at defaults).

Structure
REQ-028 A shared package SHALL hold the state enumeration (CLEAR, IDLE) and the byte-width constant 8.
REQ-029 Storage SHALL be a single sub-module spad_bank (one 2**ADDR_W x DATA_W byte-writable bank), instantiated NBANKS times; control, clear sequencer, bypass and output register stay in spad_regfile.

Verification
REQ-030 Reset 1 cycle, release -> busy_h=1 for 32 cycles, then 0; reads of all 32 entries return mbus_l=0xFFFFFFFF (zero data).
REQ-031 Write bank 1 addr 5 wbus_h=0x12345678 spw_l=0000, then read -> next cycle mbus_l=0xEDCBA987, mbus_oe_h=1; bank 0 addr 5 still reads 0xFFFFFFFF.
REQ-032 Entry holds 0x11223344; same-cycle read + write 0xAABBCCDD with spw_l=1010 -> mbus_l=~0x11BB33DD; stored value 0x11BB33DD.
REQ-033 Fill entries, pulse clr_h, write during CLEAR -> busy_h=1 for 32 cycles, mbus_oe_h=0 throughout, all entries then read 0.
REQ-034 Assert rst_h at clear pointer 10 -> busy_h remains 1 for a full 32 cycles after release.
REQ-035 Parameter run DATA_W=16, ADDR_W=3, NBANKS=3: bank_h=3 write dropped, read gives mbus_oe_h=0; clear lasts 24 cycles.
